// File: rtl/tap_judge_if.sv
// Signal bundle between the keyboard/row-pattern side and the tap judge.
// The master drives ticks, the row pattern and key presses; the slave returns the judgement.
interface tap_judge_if #(
   parameter int unsigned SCORE_W = 8
);
   logic               tick;
   logic [3:0]         bottom_row;
   logic               key_valid;
   logic [1:0]         key_col;
   logic [1:0]         click_state;
   logic [SCORE_W-1:0] score;
   logic [3:0]         lives;
   logic               lose;
   logic [3:0]         hit_mask;

   modport master (
      output tick, bottom_row, key_valid, key_col,
      input  click_state, score, lives, lose, hit_mask
   );

   modport slave (
      input  tick, bottom_row, key_valid, key_col,
      output click_state, score, lives, lose, hit_mask
   );
endinterface

// File: rtl/tap_judge.sv
// Judges column key presses against the bottom tile row on each row-advance tick,
// keeping score, lives and the lose flag; all outputs are registered.
module tap_judge #(
   parameter int unsigned LIVES   = 3,
   parameter int unsigned SCORE_W = 8
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   tap_judge_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LOAD      = 2'd1,
      S_ARMED     = 2'd2,
      S_GAME_OVER = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CLK_PAUSE = 2'd0,
      CLK_SCORE = 2'd1,
      CLK_MISS  = 2'd2
   } click_t;

   state_t               r_state,      w_state;
   click_t               r_click,      w_click;
   logic [SCORE_W-1:0]   r_score,      w_score;
   logic [3:0]           r_lives,      w_lives;
   logic                 r_lose,       w_lose;
   logic [3:0]           r_hit_mask,   w_hit_mask;
   logic [3:0]           r_row_q,      w_row_q;
   logic                 r_pend_valid, w_pend_valid;
   logic [1:0]           r_pend_col,   w_pend_col;

   logic                 w_judge;
   logic [1:0]           w_col;
   logic                 w_escape;
   logic                 w_press_hit;
   logic                 w_press_miss;
   logic [1:0]           w_miss_cnt;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_click      <= CLK_PAUSE;
         r_score      <= '0;
         r_lives      <= 4'(LIVES);
         r_lose       <= 1'b0;
         r_hit_mask   <= '0;
         r_row_q      <= '0;
         r_pend_valid <= 1'b0;
         r_pend_col   <= '0;
      end else begin
         r_state      <= w_state;
         r_click      <= w_click;
         r_score      <= w_score;
         r_lives      <= w_lives;
         r_lose       <= w_lose;
         r_hit_mask   <= w_hit_mask;
         r_row_q      <= w_row_q;
         r_pend_valid <= w_pend_valid;
         r_pend_col   <= w_pend_col;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_click      = r_click;
      w_score      = r_score;
      w_lives      = r_lives;
      w_lose       = r_lose;
      w_hit_mask   = r_hit_mask;
      w_row_q      = r_row_q;
      w_pend_valid = r_pend_valid;
      w_pend_col   = r_pend_col;
      w_judge      = 1'b0;
      w_col        = r_pend_col;
      w_escape     = 1'b0;
      w_press_hit  = 1'b0;
      w_press_miss = 1'b0;
      w_miss_cnt   = '0;

      unique case (r_state)
         S_IDLE: begin
            if (bus.tick) w_state = S_LOAD;
         end

         S_LOAD: begin
            w_row_q    = bus.bottom_row;
            w_hit_mask = '0;
            w_click    = CLK_PAUSE;
            w_state    = S_ARMED;
            if (bus.key_valid && !r_pend_valid) begin
               w_pend_valid = 1'b1;
               w_pend_col   = bus.key_col;
            end
         end

         S_ARMED: begin
            // A buffered press is judged first; a same-cycle press refills the buffer.
            // Presses arriving with a tick are held for the next row.
            if (r_pend_valid) begin
               w_judge      = 1'b1;
               w_col        = r_pend_col;
               w_pend_valid = bus.key_valid;
               if (bus.key_valid) w_pend_col = bus.key_col;
            end else if (bus.key_valid) begin
               if (bus.tick) begin
                  w_pend_valid = 1'b1;
                  w_pend_col   = bus.key_col;
               end else begin
                  w_judge = 1'b1;
                  w_col   = bus.key_col;
               end
            end

            w_escape = bus.tick && (|(r_row_q & ~r_hit_mask));

            if (w_judge) begin
               if (r_row_q[w_col]) begin
                  if (!r_hit_mask[w_col]) begin
                     w_press_hit        = 1'b1;
                     w_hit_mask[w_col]  = 1'b1;
                  end
               end else begin
                  w_press_miss = 1'b1;
               end
            end

            if (w_press_hit) begin
               w_click = CLK_SCORE;
               if (r_score != '1) w_score = r_score + SCORE_W'(1);
            end

            w_miss_cnt = {1'b0, w_press_miss} + {1'b0, w_escape};
            if (w_miss_cnt != 2'd0) begin
               w_click = CLK_MISS;
               w_lives = (r_lives > {2'b00, w_miss_cnt}) ? (r_lives - {2'b00, w_miss_cnt}) : 4'd0;
            end

            if (bus.tick) w_state = S_LOAD;

            if ((w_miss_cnt != 2'd0) && (w_lives == 4'd0)) begin
               w_state      = S_GAME_OVER;
               w_lose       = 1'b1;
               w_click      = CLK_MISS;
               w_pend_valid = 1'b0;
            end
         end

         S_GAME_OVER: begin
            w_lose  = 1'b1;
            w_click = CLK_MISS;
         end

         default: w_state = S_IDLE;
      endcase
   end

   assign bus.click_state = r_click;
   assign bus.score       = r_score;
   assign bus.lives       = r_lives;
   assign bus.lose        = r_lose;
   assign bus.hit_mask    = r_hit_mask;

endmodule
